alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 104 ++++++++++
 tb/tb_alu_seq_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Two-beat command sequencer for an external ALU: operand beat, op beat, one EXEC cycle, held response.
// Optional ALU_SEQ_CHAIN_EN: op beat bit 3 feeds the previous result back as operand A.
module alu_seq_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_data,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_sel,
  input  logic [7:0]       alu_y,
  input  logic             alu_zero,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic [1:0]       rsp_flags,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, GET_OP, EXEC, RESP} state_t;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] flags;
  } rsp_t;

  state_t           state, state_nxt;
  logic [3:0]       a_q, b_q;
  logic [2:0]       sel_q;
  rsp_t             rsp_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cmd_hs, rsp_hs;

  assign cmd_hs = cmd_valid & cmd_ready;
  assign rsp_hs = rsp_valid & rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_hs) state_nxt = GET_OP;
      end
      GET_OP: begin
        cmd_ready = 1'b1;
        if (cmd_hs) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/select registers drive the ALU directly so its inputs only move on a capture edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sel_q <= '0;
      rsp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (state == IDLE && cmd_hs) begin
        a_q <= cmd_data[7:4];
        b_q <= cmd_data[3:0];
      end
      if (state == GET_OP && cmd_hs) begin
        sel_q <= cmd_data[2:0];
`ifdef ALU_SEQ_CHAIN_EN
        if (cmd_data[3]) a_q <= rsp_q.data[3:0];
`endif
      end
      if (state == EXEC) begin
        rsp_q.data  <= alu_y;
        rsp_q.flags <= {alu_carry, alu_zero};
      end
      if (rsp_hs) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;
  assign rsp_data  = rsp_q.data;
  assign rsp_flags = rsp_q.flags;
  assign op_count  = cnt_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural 4-bit ALU on the downstream side.
module tb_alu_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_y;
  logic       alu_zero, alu_carry;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_flags;
  logic       busy;
  logic [7:0] op_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_y(alu_y), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .busy(busy), .op_count(op_count)
  );

  // 4-bit ALU: result in the low nibble, carry/borrow out separately
  logic [4:0] r5;
  always_comb begin
    r5 = '0;
    case (alu_sel)
      3'd0: r5 = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: r5 = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: r5 = {1'b0, alu_a & alu_b};
      3'd3: r5 = {1'b0, alu_a | alu_b};
      3'd4: r5 = {1'b0, alu_a ^ alu_b};
      3'd5: r5 = {1'b0, ~alu_a};
      3'd6: r5 = {alu_a, 1'b0};
      default: r5 = {1'b0, alu_a >> 1};
    endcase
  end
  assign alu_y     = {4'h0, r5[3:0]};
  assign alu_carry = r5[4];
  assign alu_zero  = (r5[3:0] == 4'h0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic beat(input logic [7:0] d);
    int t;
    t = 0;
    cmd_valid = 1'b1;
    cmd_data  = d;
    while (!cmd_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 20) chk("beat_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Full operation with rsp_ready high; returns 1 time unit after the response handshake edge.
  task automatic do_op(input logic [7:0] b0, input logic [7:0] b1);
    int t;
    beat(b0);
    beat(b1);
    t = 0;
    while (!rsp_valid && t < 10) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 10) chk("rsp_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_op_count", op_count, 0);
    rst_n = 1'b1;
    chk("rst_cmd_ready", cmd_ready, 1);

    // 3 + 5, rsp_ready already high: valid two cycles after the op beat
    rsp_ready = 1'b1;
    beat(8'h35);
    chk("t1_getop_busy", busy, 1);
    beat(8'h00);
    chk("t1_alu_a", alu_a, 3);
    chk("t1_alu_b", alu_b, 5);
    chk("t1_alu_sel", alu_sel, 0);
    chk("t1_exec_valid", rsp_valid, 0);
    chk("t1_exec_ready", cmd_ready, 0);
    @(posedge clk); #1;
    chk("t1_valid", rsp_valid, 1);
    chk("t1_data", rsp_data, 8'h08);
    chk("t1_flags", rsp_flags, 2'b00);
    @(posedge clk); #1;
    chk("t1_count", op_count, 1);
    chk("t1_idle_valid", rsp_valid, 0);
    chk("t1_idle_busy", busy, 0);

    // 15 + 1 wraps the nibble: carry and zero
    do_op(8'hF1, 8'h00);
    chk("t2_data", rsp_data, 8'h00);
    chk("t2_flags", rsp_flags, 2'b11);
    chk("t2_count", op_count, 2);

    // 5 - 3
    do_op(8'h53, 8'h01);
    chk("t3_data", rsp_data, 8'h02);
    chk("t3_flags", rsp_flags, 2'b00);
    chk("t3_count", op_count, 3);

    // back-pressure in RESP for 5 cycles
    rsp_ready = 1'b0;
    beat(8'h35);
    beat(8'h00);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", rsp_valid, 1);
      chk("t4_hold_data", rsp_data, 8'h08);
      chk("t4_hold_ready", cmd_ready, 0);
      chk("t4_hold_busy", busy, 1);
      chk("t4_hold_count", op_count, 3);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_count", op_count, 4);
    chk("t4_valid_low", rsp_valid, 0);
    chk("t4_data_kept", rsp_data, 8'h08);
    @(posedge clk); #1;
    chk("t4_count_once", op_count, 4);

    // chaining: previous result 0x08, op beat bit3 set
    beat(8'h12);
    beat(8'h08);
`ifdef ALU_SEQ_CHAIN_EN
    chk("t5_alu_a", alu_a, 8);
`else
    chk("t5_alu_a", alu_a, 1);
`endif
    chk("t5_alu_b", alu_b, 2);
    @(posedge clk); #1;
`ifdef ALU_SEQ_CHAIN_EN
    chk("t5_data", rsp_data, 8'h0A);
`else
    chk("t5_data", rsp_data, 8'h03);
`endif
    @(posedge clk); #1;
    chk("t5_count", op_count, 5);

    // reset during EXEC discards the operation
    beat(8'h35);
    beat(8'h00);
    chk("t6_in_exec", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t6_valid", rsp_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("t6_alu_a", alu_a, 0);
    chk("t6_alu_b", alu_b, 0);
    chk("t6_alu_sel", alu_sel, 0);
    chk("t6_rsp_data", rsp_data, 0);
    chk("t6_rsp_flags", rsp_flags, 0);
    chk("t6_count", op_count, 0);
    @(posedge clk); #1;
    chk("t6_no_pulse", rsp_valid, 0);

    // counter wrap
    for (int i = 0; i < 255; i++) do_op(8'h11, 8'h00);
    chk("t7_count_max", op_count, 255);
    do_op(8'h11, 8'h00);
    chk("t7_count_wrap", op_count, 0);
    chk("t7_data", rsp_data, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
